// File: rtl/fifo_controller_pkg.sv
// Shared helpers for the FIFO controller: pointer arithmetic that works for
// any depth, not just powers of two.
package fifo_controller_pkg;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/dual_port_memory.sv
// Simple dual-port RAM: one write port, one read port with a registered
// read_data that holds its value whenever no read is enabled.
module dual_port_memory #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512
) (
  input  logic                                        write_clock,
  input  logic                                        write_clock_enable,
  input  logic                                        write_enable,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] write_addr,
  input  logic [WIDTH-1:0]                            write_data,
  input  logic                                        read_clock,
  input  logic                                        read_clock_enable,
  input  logic                                        read_enable,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] read_addr,
  output logic [WIDTH-1:0]                            read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; only control state needs one.
  always_ff @(posedge write_clock) begin
    if (write_clock_enable && write_enable) mem[write_addr] <= write_data;
  end

  always_ff @(posedge read_clock) begin
    if (read_clock_enable && read_enable) read_data <= mem[read_addr];
  end

endmodule

// File: rtl/fifo_controller.sv
// Single-clock first-word-fall-through FIFO; the memory's registered read
// port doubles as the output stage, so count includes that word.
module fifo_controller
  import fifo_controller_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 512,
  parameter int ALMOST_FULL = DEPTH - 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_count_q, mem_count_d;
  logic             out_valid_q, out_valid_d;
  logic             flush, push, pop, issue;

  always_comb begin
    flush       = reset || clear;
    count       = mem_count_q + CNT_W'(out_valid_q);
    in_ready    = count < CNT_W'(DEPTH);
    empty       = (count == '0);
    almost_full = int'(count) >= ALMOST_FULL;
    out_valid   = out_valid_q;

    // A flushing cycle neither writes nor launches a read.
    push  = in_valid && in_ready && !flush;
    pop   = out_valid_q && out_ready;
    issue = (mem_count_q != '0) && (!out_valid_q || out_ready) && !flush;

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_valid_d = out_valid_q;

    if (push)  wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
    if (issue) rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));

    case ({push, issue})
      2'b10:   mem_count_d = mem_count_q + 1'b1;
      2'b01:   mem_count_d = mem_count_q - 1'b1;
      default: mem_count_d = mem_count_q;
    endcase

    if (issue)    out_valid_d = 1'b1;
    else if (pop) out_valid_d = 1'b0;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  dual_port_memory #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .write_clock       (clock),
    .write_clock_enable(1'b1),
    .write_enable      (push),
    .write_addr        (wr_ptr_q),
    .write_data        (in_data),
    .read_clock        (clock),
    .read_clock_enable (1'b1),
    .read_enable       (issue),
    .read_addr         (rd_ptr_q),
    .read_data         (out_data)
  );

endmodule
